// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational barrel shifter between two
// valid/ready requesters, with a one-entry registered result buffer.
module shift_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned SW = 5
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_data,
    input  logic [SW-1:0] req0_num,
    input  logic [1:0]    req0_ctr,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_data,
    input  logic [SW-1:0] req1_num,
    input  logic [1:0]    req1_ctr,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          prio_q, prio_d;
    logic          id_q, id_d;
    logic [DW-1:0] data_q, data_d;

    logic          can_accept;
    logic          grant;
    logic          accept;
    logic [DW-1:0] g_data;
    logic [SW-1:0] g_num;
    logic [1:0]    g_ctr;
    logic [DW-1:0] shift_res;

    // Arithmetic right uses the signed shift so no explicit fill mask (and no
    // shift-by-DW corner) is ever formed.
    function automatic logic [DW-1:0] shift_fn(
        input logic [DW-1:0] d,
        input logic [SW-1:0] n,
        input logic [1:0]    c
    );
        logic [DW-1:0] r;
        case (c)
            2'b11:   r = DW'($signed(d) >>> n);
            2'b10:   r = d >> n;
            default: r = d << n;
        endcase
        return r;
    endfunction

    // Arbitration and ready generation; readies are held low during reset.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || rsp_ready;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            grant = 1'b1;
        end else begin
            grant = prio_q;
        end
        req0_ready = rst_n && can_accept && !grant && req0_valid;
        req1_ready = rst_n && can_accept &&  grant && req1_valid;
        accept     = req0_ready || req1_ready;
        g_data     = grant ? req1_data : req0_data;
        g_num      = grant ? req1_num  : req0_num;
        g_ctr      = grant ? req1_ctr  : req0_ctr;
        shift_res  = shift_fn(g_data, g_num, g_ctr);
    end

    // Buffer next state: accept overrides drain so refill keeps rsp_valid high.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        data_d  = data_q;
        if (accept) begin
            state_d = ST_FULL;
            prio_d  = ~grant;
            id_d    = grant;
            data_d  = shift_res;
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vectors, corner sequences and
// randomized traffic against a bit-level behavioural model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_num, req1_num;
    logic [1:0]  req0_ctr, req1_ctr;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    // Model state
    bit        m_full;
    bit        m_prio;
    bit        m_id;
    bit [31:0] m_data;

    always #5 clk = ~clk;

    shift_arbiter #(.DW(32), .SW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_num(req0_num), .req0_ctr(req0_ctr),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_num(req1_num), .req1_ctr(req1_ctr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  num;
        logic [1:0]  ctr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-by-bit shift from the mode rules.
    function automatic bit [31:0] ref_shift(input bit [31:0] d, input int n, input bit [1:0] c);
        bit [31:0] r;
        for (int i = 0; i < 32; i++) begin
            if (c == 2'b11)      r[i] = (i + n < 32) ? d[i + n] : d[31];
            else if (c == 2'b10) r[i] = (i + n < 32) ? d[i + n] : 1'b0;
            else                 r[i] = (i >= n) ? d[i - n] : 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_full = 0; m_prio = 0; m_id = 0; m_data = '0;
    endtask

    // One clock cycle: called just after an edge; drives inputs, checks readies
    // mid-cycle, advances the model at the edge and checks the buffer after it.
    task automatic cycle(input bit v0, input bit [31:0] d0, input bit [4:0] n0, input bit [1:0] c0,
                         input bit v1, input bit [31:0] d1, input bit [4:0] n1, input bit [1:0] c1,
                         input bit rr);
        bit acc_ok, g, e0, e1;
        req0_valid = v0; req0_data = d0; req0_num = n0; req0_ctr = c0;
        req1_valid = v1; req1_data = d1; req1_num = n1; req1_ctr = c1;
        rsp_ready  = rr;
        #2;
        acc_ok = !m_full || rr;
        g  = (v0 && v1) ? m_prio : v1;
        e0 = acc_ok && v0 && !g;
        e1 = acc_ok && v1 && g;
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
        @(posedge clk);
        if (e0 || e1) begin
            m_data = g ? ref_shift(d1, int'(n1), c1) : ref_shift(d0, int'(n0), c0);
            m_id   = g;
            m_full = 1;
            m_prio = ~g;
        end else if (m_full && rr) begin
            m_full = 0;
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_data", rsp_data, m_data);
    endtask

    task automatic idle(input bit rr);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    bit        h0_v, h1_v;
    bit [31:0] h0_d, h1_d;
    bit [4:0]  h0_n, h1_n;
    bit [1:0]  h0_c, h1_c;
    bit        p0, p1;

    initial begin
        vecs[0] = '{32'h8000_0000, 5'd4,  2'b11, 32'hF800_0000};
        vecs[1] = '{32'h8000_0000, 5'd4,  2'b10, 32'h0800_0000};
        vecs[2] = '{32'h0000_00F1, 5'd4,  2'b00, 32'h0000_0F10};
        vecs[3] = '{32'h8000_0001, 5'd0,  2'b11, 32'h8000_0001};
        vecs[4] = '{32'h8000_0001, 5'd31, 2'b11, 32'hFFFF_FFFF};
        vecs[5] = '{32'h8000_0001, 5'd31, 2'b10, 32'h0000_0001};
        vecs[6] = '{32'h8000_0001, 5'd31, 2'b01, 32'h8000_0000};

        // Reset state, with requests visible to show readies are gated.
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = '1; req0_num = '0; req0_ctr = '0;
        req1_valid = 1'b1; req1_data = '1; req1_num = '0; req1_ctr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        rst_n = 1'b1;

        // Fairness from reset: both valid, expect ids 0,1,0,1,0,1.
        for (int i = 0; i < 6; i++) begin
            cycle(1, 32'h1 << i, 5'd1, 2'b00, 1, 32'h100 << i, 5'd2, 2'b10, 1);
            chk("fair_id", 32'(rsp_id), 32'(i % 2));
        end
        idle(1);

        // Mode and edge-amount vectors, requester 0 only.
        foreach (vecs[i]) begin
            cycle(1, vecs[i].data, vecs[i].num, vecs[i].ctr, 0, 0, 0, 0, 1);
            chk("vec_data", rsp_data, vecs[i].exp);
            chk("vec_id", 32'(rsp_id), 32'd0);
        end
        idle(1);

        // Backpressure: buffer one result, stall 3 cycles, then drain+refill.
        cycle(1, 32'h1234_5678, 5'd8, 2'b00, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 32'hAAAA_0000, 5'd3, 2'b10, 1, 32'h5555_0000, 5'd5, 2'b11, 0);
            chk("bp_frozen", rsp_data, 32'h3456_7800);
        end
        cycle(1, 32'hAAAA_0000, 5'd3, 2'b10, 1, 32'h5555_0000, 5'd5, 2'b11, 1);
        chk("bp_refill_valid", 32'(rsp_valid), 32'd1);
        chk("bp_refill_id", 32'(rsp_id), 32'd1);
        chk("bp_refill_data", rsp_data, 32'h02AA_A800);

        // Reset mid-operation while FULL.
        cycle(1, 32'hDEAD_BEEF, 5'd0, 2'b00, 0, 0, 0, 0, 0);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_data", rsp_data, 32'd0);
        chk("midrst_ready0", 32'(req0_ready), 32'd0);
        chk("midrst_ready1", 32'(req1_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(0, 0, 0, 0, 1, 32'hF000_000F, 5'd4, 2'b11, 1);
        chk("post_rst_id", 32'(rsp_id), 32'd1);

        // Requester 1 streaming back-to-back.
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 0, 1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom), 1);
            chk("stream_valid", 32'(rsp_valid), 32'd1);
            chk("stream_id", 32'(rsp_id), 32'd1);
        end

        // Randomized traffic; a requester holds its operands until accepted.
        h0_v = 0; h1_v = 0;
        for (int i = 0; i < 400; i++) begin
            if (!h0_v) begin
                h0_v = ($urandom_range(0, 3) != 0);
                h0_d = $urandom; h0_n = 5'($urandom); h0_c = 2'($urandom);
            end
            if (!h1_v) begin
                h1_v = ($urandom_range(0, 3) != 0);
                h1_d = $urandom; h1_n = 5'($urandom); h1_c = 2'($urandom);
            end
            cycle(h0_v, h0_d, h0_n, h0_c, h1_v, h1_d, h1_n, h1_c, ($urandom_range(0, 3) != 0));
            p0 = h0_v && m_full && (m_id == 1'b0) && (m_data == ref_shift(h0_d, int'(h0_n), h0_c));
            p1 = h1_v && m_full && (m_id == 1'b1) && (m_data == ref_shift(h1_d, int'(h1_n), h1_c));
            // Model just recorded an acceptance if its id/data match a held request.
            if (p0 && m_prio == 1'b1) h0_v = 0;
            if (p1 && m_prio == 1'b0) h1_v = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single combinational 32-bit shifter between two requesters, such as the ALU issue path and the address/immediate formation path, using round-robin arbitration. Each request uses a valid/ready handshake. The block registers the shift result together with the requester ID in a one-entry output buffer, which is drained through its own valid/ready handshake. When the consumer keeps draining, the block sustains one shift per cycle.

## Interface

Parameters:
- DW, 32, data width
- SW, 5, shift-amount width (log2 DW)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- req0_valid  in  1  requester 0 has a shift pending
- req0_ready  out  1  requester 0 accepted this cycle
- req0_data  in  DW  operand
- req0_num  in  SW  shift amount, 0..DW-1
- req0_ctr  in  2  11 = arithmetic right, 10 = logical right, 01/00 = left
- req1_valid, req1_ready, req1_data, req1_num, req1_ctr: same as requester 0, for requester 1
- rsp_valid  out  1  result buffer holds a result
- rsp_ready  in  1  consumer takes the result this cycle
- rsp_id  out  1  requester that produced rsp_data
- rsp_data  out  DW  shift result

## Operation

Shift function:
- Left: data << num, zero fill.
- Logical right: data >> num, zero fill.
- Arithmetic right: data >> num with the vacated upper num bits set to data[DW-1].
- num = 0 returns data unchanged for all three modes.

Buffer state machine, two states:
- EMPTY: rsp_valid = 0.
- FULL: rsp_valid = 1.
- can_accept = EMPTY, or FULL with rsp_ready = 1 (drain and refill in the same cycle).

Arbitration:
- Combinational each cycle.
- Priority register prio (1 bit). prio = k means requester k wins a tie.
- Only requester 0 valid → grant 0. Only requester 1 valid → grant 1. Both valid → grant prio.
- reqN_ready = can_accept AND grant == N AND reqN_valid. At most one ready is high per cycle.
- On acceptance of requester g: prio ← ~g. Otherwise prio holds.

Accept edge (some reqN_ready = 1):
- rsp_data ← shift(granted inputs); rsp_id ← g; state ← FULL.

Drain edge (rsp_valid & rsp_ready, no accept): state ← EMPTY. rsp_data and rsp_id hold their last values.

FULL with rsp_ready = 0:
- rsp_valid, rsp_id and rsp_data are frozen.
- Both req_ready outputs are 0.
- Requester inputs are ignored.

Requester obligations:
- Once reqN_valid is high, the requester keeps its inputs stable until reqN_ready is seen.
- Withdrawal before acceptance is tolerated: the block only samples on the ready cycle.

## Timing

Reset (rst_n = 0, asynchronous, at any time including mid-transfer):
- state = EMPTY, rsp_valid = 0, rsp_id = 0, rsp_data = 0, prio = 0.
- req0_ready and req1_ready are 0 while rst_n = 0.
- Any pending or buffered result is discarded.
- Release is synchronous to the next rising edge; requests can be accepted in the first cycle after release.

Latency and throughput:
- Latency: 1 cycle, from the accept edge to rsp_valid = 1 with the result.
- Throughput: 1 result per cycle while rsp_ready = 1.
- Ready paths are combinational: reqN_ready depends combinationally on reqN_valid and rsp_ready. There is no combinational path from req inputs to rsp outputs.

Boundary conditions:
- Simultaneous drain and accept in FULL: new data replaces old at the same edge and rsp_valid stays 1.
- Both requesters continuously valid with rsp_ready = 1: grants alternate 0, 1, 0, 1, … starting from prio.
- Neither requester valid: prio unchanged.
- num values DW-1 and 0 are both legal. Width arithmetic must not produce a shift of DW on the fill mask.

## Test plan

- Modes, requester 0 only, rsp_ready = 1:
  - data 0x8000_0000, num 4, ctr 11 → rsp_data 0xF800_0000, rsp_id 0, one cycle later.
  - ctr 10 → 0x0800_0000.
  - data 0x0000_00F1, ctr 00, num 4 → 0x0000_0F10.
- Edge amounts:
  - data 0x8000_0001, num 0, ctr 11 → 0x8000_0001.
  - num 31, ctr 11 → 0xFFFF_FFFF.
  - num 31, ctr 10 → 0x0000_0001.
  - num 31, ctr 01 → 0x8000_0000.
- Fairness: both requesters held valid for 6 cycles from reset, rsp_ready = 1 → rsp_id sequence 0, 1, 0, 1, 0, 1, with exactly one ready high per cycle.
- Backpressure: after a result is buffered, hold rsp_ready = 0 for 3 cycles with both requesters valid → rsp_data/rsp_id frozen, both readies 0. Raise rsp_ready → drain and accept on the same edge, rsp_valid never drops.
- Reset mid-operation: assert rst_n low between clock edges while FULL → rsp_valid falls immediately, rsp_data = 0. After release, requester 1 alone gets its first grant on the first cycle.
- Single requester streaming: requester 1 valid every cycle with changing data, rsp_ready = 1 → results appear back-to-back, in order, each one cycle after acceptance, rsp_id = 1.
